// File: rtl/rvfi_retire_queue.sv
// RVFI retirement collector: compacts up to NRET retire lanes per cycle, numbers them, and drains one per cycle.
// Optional memory-access fields are compiled in with `define RVFI_RETQ_MEM_EN.
module rvfi_retire_queue #(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NRET-1:0]            ret_valid,
    input  logic [NRET*XLEN-1:0]       ret_pc_rdata,
    input  logic [NRET*XLEN-1:0]       ret_pc_wdata,
    input  logic [NRET*32-1:0]         ret_insn,
    input  logic [NRET-1:0]            ret_trap,
    input  logic [NRET-1:0]            ret_intr,
    input  logic [NRET*5-1:0]          ret_rd_addr,
    input  logic [NRET*XLEN-1:0]       ret_rd_wdata,
    input  logic [NRET-1:0]            ret_wr_valid,
`ifdef RVFI_RETQ_MEM_EN
    input  logic [NRET*XLEN-1:0]       ret_mem_addr,
    input  logic [NRET*XLEN/8-1:0]     ret_mem_rmask,
    input  logic [NRET*XLEN/8-1:0]     ret_mem_wmask,
    input  logic [NRET*XLEN-1:0]       ret_mem_rdata,
    input  logic [NRET*XLEN-1:0]       ret_mem_wdata,
    input  logic [NRET-1:0]            ret_mem_fault,
`endif
    output logic                       ret_stall,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_order,
    output logic [XLEN-1:0]            out_pc_rdata,
    output logic [XLEN-1:0]            out_pc_wdata,
    output logic [31:0]                out_insn,
    output logic                       out_trap,
    output logic                       out_intr,
    output logic                       out_int_valid,
    output logic [4:0]                 out_rd_addr,
    output logic [XLEN-1:0]            out_rd_wdata,
`ifdef RVFI_RETQ_MEM_EN
    output logic                       out_mem_valid,
    output logic [XLEN-1:0]            out_mem_addr,
    output logic [XLEN/8-1:0]          out_mem_rmask,
    output logic [XLEN/8-1:0]          out_mem_wmask,
    output logic [XLEN-1:0]            out_mem_rdata,
    output logic [XLEN-1:0]            out_mem_wdata,
    output logic                       out_mem_fault,
`endif
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned LW = $clog2(NRET + 1);
`ifdef RVFI_RETQ_MEM_EN
    localparam int unsigned MW = XLEN / 8;
`endif

    typedef struct packed {
        logic [63:0]     order;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [31:0]     insn;
        logic            trap;
        logic            intr;
        logic            int_valid;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
`ifdef RVFI_RETQ_MEM_EN
        logic            mem_valid;
        logic [XLEN-1:0] mem_addr;
        logic [MW-1:0]   mem_rmask;
        logic [MW-1:0]   mem_wmask;
        logic [XLEN-1:0] mem_rdata;
        logic [XLEN-1:0] mem_wdata;
        logic            mem_fault;
`endif
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [63:0]     order_ctr;

    entry_t          lane_e    [NRET];
    logic [PW-1:0]   lane_slot [NRET];
    logic [LW-1:0]   n_push;
    logic [LW-1:0]   n_adv;
    logic            accept;
    logic            pop;
    entry_t          head;

    // Per-lane packet build: slot is the compacted index, order offset counts prior non-trap/intr packets
    always_comb begin
        n_push = '0;
        n_adv  = '0;
        for (int i = 0; i < NRET; i++) begin
            lane_slot[i]          = wr_ptr + PW'(n_push);
            lane_e[i]             = '0;
            lane_e[i].order       = order_ctr + 64'(n_adv);
            lane_e[i].pc_rdata    = ret_pc_rdata[i*XLEN +: XLEN];
            lane_e[i].pc_wdata    = ret_pc_wdata[i*XLEN +: XLEN];
            lane_e[i].insn        = ret_insn[i*32 +: 32];
            lane_e[i].trap        = ret_trap[i];
            lane_e[i].intr        = ret_intr[i];
            lane_e[i].int_valid   = !ret_trap[i] && (ret_rd_addr[i*5 +: 5] != 5'd0) && ret_wr_valid[i];
            if (lane_e[i].int_valid) begin
                lane_e[i].rd_addr  = ret_rd_addr[i*5 +: 5];
                lane_e[i].rd_wdata = ret_rd_wdata[i*XLEN +: XLEN];
            end
`ifdef RVFI_RETQ_MEM_EN
            lane_e[i].mem_addr  = ret_mem_addr[i*XLEN +: XLEN];
            lane_e[i].mem_rdata = ret_mem_rdata[i*XLEN +: XLEN];
            lane_e[i].mem_wdata = ret_mem_wdata[i*XLEN +: XLEN];
            lane_e[i].mem_fault = ret_mem_fault[i];
            // A trap without an access fault never performed the access
            if (!ret_trap[i] || ret_mem_fault[i]) begin
                lane_e[i].mem_rmask = ret_mem_rmask[i*MW +: MW];
                lane_e[i].mem_wmask = ret_mem_wmask[i*MW +: MW];
            end
            lane_e[i].mem_valid = (lane_e[i].mem_rmask | lane_e[i].mem_wmask) != '0;
`endif
            if (ret_valid[i]) begin
                n_push = n_push + 1'b1;
                if (!ret_trap[i] && !ret_intr[i]) begin
                    n_adv = n_adv + 1'b1;
                end
            end
        end
    end

    // Conservative accept: free space is judged before this cycle's pop
    assign accept    = CW'(n_push) <= (CW'(DEPTH) - count);
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign ret_stall = (CW'(DEPTH) - count) < CW'(NRET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            order_ctr <= '0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr    <= wr_ptr + PW'(n_push);
                order_ctr <= order_ctr + 64'(n_adv);
            end else begin
                overflow  <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (accept ? CW'(n_push) : CW'(0)) - CW'(pop);
        end
    end

    // Storage carries no reset; validity is tracked by count alone
    always_ff @(posedge clk) begin
        for (int i = 0; i < NRET; i++) begin
            if (accept && ret_valid[i]) begin
                mem[lane_slot[i]] <= lane_e[i];
            end
        end
    end

    // Head read is zero-latency and forced to zero while empty
    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign out_order     = head.order;
    assign out_pc_rdata  = head.pc_rdata;
    assign out_pc_wdata  = head.pc_wdata;
    assign out_insn      = head.insn;
    assign out_trap      = head.trap;
    assign out_intr      = head.intr;
    assign out_int_valid = head.int_valid;
    assign out_rd_addr   = head.rd_addr;
    assign out_rd_wdata  = head.rd_wdata;
`ifdef RVFI_RETQ_MEM_EN
    assign out_mem_valid = head.mem_valid;
    assign out_mem_addr  = head.mem_addr;
    assign out_mem_rmask = head.mem_rmask;
    assign out_mem_wmask = head.mem_wmask;
    assign out_mem_rdata = head.mem_rdata;
    assign out_mem_wdata = head.mem_wdata;
    assign out_mem_fault = head.mem_fault;
`endif

endmodule

// File: tb/tb_rvfi_retire_queue.sv
// Bench for rvfi_retire_queue: directed scenarios plus a randomized run against a queue-based reference.
module tb_rvfi_retire_queue;

    localparam int unsigned NRET  = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned XLEN  = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NRET-1:0]       ret_valid;
    logic [NRET*XLEN-1:0]  ret_pc_rdata, ret_pc_wdata, ret_rd_wdata;
    logic [NRET*32-1:0]    ret_insn;
    logic [NRET-1:0]       ret_trap, ret_intr, ret_wr_valid;
    logic [NRET*5-1:0]     ret_rd_addr;
    logic                  ret_stall, out_valid, out_ready;
    logic [63:0]           out_order;
    logic [XLEN-1:0]       out_pc_rdata, out_pc_wdata, out_rd_wdata;
    logic [31:0]           out_insn;
    logic                  out_trap, out_intr, out_int_valid;
    logic [4:0]            out_rd_addr;
    logic [3:0]            count;
    logic                  overflow;
`ifdef RVFI_RETQ_MEM_EN
    logic [NRET*XLEN-1:0]   ret_mem_addr = '0, ret_mem_rdata = '0, ret_mem_wdata = '0;
    logic [NRET*XLEN/8-1:0] ret_mem_rmask = '0, ret_mem_wmask = '0;
    logic [NRET-1:0]        ret_mem_fault = '0;
    logic                   out_mem_valid, out_mem_fault;
    logic [XLEN-1:0]        out_mem_addr, out_mem_rdata, out_mem_wdata;
    logic [XLEN/8-1:0]      out_mem_rmask, out_mem_wmask;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rvfi_retire_queue #(.NRET(NRET), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .ret_valid(ret_valid), .ret_pc_rdata(ret_pc_rdata), .ret_pc_wdata(ret_pc_wdata),
        .ret_insn(ret_insn), .ret_trap(ret_trap), .ret_intr(ret_intr),
        .ret_rd_addr(ret_rd_addr), .ret_rd_wdata(ret_rd_wdata), .ret_wr_valid(ret_wr_valid),
`ifdef RVFI_RETQ_MEM_EN
        .ret_mem_addr(ret_mem_addr), .ret_mem_rmask(ret_mem_rmask), .ret_mem_wmask(ret_mem_wmask),
        .ret_mem_rdata(ret_mem_rdata), .ret_mem_wdata(ret_mem_wdata), .ret_mem_fault(ret_mem_fault),
`endif
        .ret_stall(ret_stall), .out_valid(out_valid), .out_ready(out_ready),
        .out_order(out_order), .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
        .out_insn(out_insn), .out_trap(out_trap), .out_intr(out_intr),
        .out_int_valid(out_int_valid), .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
`ifdef RVFI_RETQ_MEM_EN
        .out_mem_valid(out_mem_valid), .out_mem_addr(out_mem_addr), .out_mem_rmask(out_mem_rmask),
        .out_mem_wmask(out_mem_wmask), .out_mem_rdata(out_mem_rdata), .out_mem_wdata(out_mem_wdata),
        .out_mem_fault(out_mem_fault),
`endif
        .count(count), .overflow(overflow)
    );

    typedef struct {
        logic [63:0] order;
        logic [31:0] pc_r, pc_w, insn, wd;
        logic        trap, intr, iv;
        logic [4:0]  rd;
    } exp_t;

    task automatic clear_inputs();
        ret_valid = '0; ret_pc_rdata = '0; ret_pc_wdata = '0; ret_insn = '0;
        ret_trap = '0; ret_intr = '0; ret_rd_addr = '0; ret_rd_wdata = '0; ret_wr_valid = '0;
    endtask

    task automatic set_lane(input int i, input logic [31:0] pc, input logic [31:0] insn,
                            input logic trap, input logic intr, input logic [4:0] rd,
                            input logic [31:0] wd, input logic wv);
        ret_valid[i] = 1'b1;
        ret_pc_rdata[i*32 +: 32] = pc;
        ret_pc_wdata[i*32 +: 32] = pc + 32'd4;
        ret_insn[i*32 +: 32] = insn;
        ret_trap[i] = trap;
        ret_intr[i] = intr;
        ret_rd_addr[i*5 +: 5] = rd;
        ret_rd_wdata[i*32 +: 32] = wd;
        ret_wr_valid[i] = wv;
    endtask

    task automatic do_reset();
        clear_inputs();
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got %0d want 0", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
        total++; if (ret_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", ret_stall); end
        total++; if (out_order !== 64'd0 || out_pc_rdata !== 32'd0) begin bad++; $display("FAIL reset_data got order=%0d pc=%h want 0", out_order, out_pc_rdata); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        set_lane(0, 32'h8000_0000, 32'h0070_0293, 1'b0, 1'b0, 5'd5, 32'd7, 1'b1);
        @(negedge clk);
        clear_inputs();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got %b want 1", out_valid); end
        total++; if (out_order !== 64'd0) begin bad++; $display("FAIL single_order got %0d want 0", out_order); end
        total++; if (out_rd_addr !== 5'd5 || out_rd_wdata !== 32'd7) begin bad++; $display("FAIL single_rd got %0d/%0d want 5/7", out_rd_addr, out_rd_wdata); end
        total++; if (out_int_valid !== 1'b1) begin bad++; $display("FAIL single_int_valid got %b want 1", out_int_valid); end
        total++; if (out_pc_rdata !== 32'h8000_0000 || out_pc_wdata !== 32'h8000_0004) begin bad++; $display("FAIL single_pc got %h/%h want 80000000/80000004", out_pc_rdata, out_pc_wdata); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drained got %b want 0", out_valid); end
    endtask

    task automatic test_dual();
        do_reset();
        out_ready = 1'b1;
        set_lane(0, 32'h100, 32'h13, 1'b0, 1'b0, 5'd1, 32'd11, 1'b1);
        set_lane(1, 32'h104, 32'h13, 1'b0, 1'b0, 5'd2, 32'd22, 1'b1);
        @(negedge clk);
        clear_inputs();
        total++; if (out_order !== 64'd0 || out_pc_rdata !== 32'h100 || count !== 4'd2) begin bad++; $display("FAIL dual_first got order=%0d pc=%h cnt=%0d want 0/100/2", out_order, out_pc_rdata, count); end
        @(negedge clk);
        total++; if (out_order !== 64'd1 || out_pc_rdata !== 32'h104 || out_rd_wdata !== 32'd22) begin bad++; $display("FAIL dual_second got order=%0d pc=%h wd=%0d want 1/104/22", out_order, out_pc_rdata, out_rd_wdata); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dual_empty got %b want 0", out_valid); end
        set_lane(1, 32'h200, 32'h13, 1'b0, 1'b0, 5'd9, 32'd99, 1'b1);
        @(negedge clk);
        clear_inputs();
        total++; if (count !== 4'd1 || out_pc_rdata !== 32'h200 || out_order !== 64'd2) begin bad++; $display("FAIL dual_lane1_compact got cnt=%0d pc=%h order=%0d want 1/200/2", count, out_pc_rdata, out_order); end
    endtask

    task automatic test_trap();
        do_reset();
        set_lane(0, 32'h300, 32'h0000_0073, 1'b1, 1'b0, 5'd3, 32'd5, 1'b1);
        set_lane(1, 32'h304, 32'h13, 1'b0, 1'b0, 5'd4, 32'd44, 1'b1);
        @(negedge clk);
        clear_inputs();
        total++; if (out_order !== 64'd0 || out_trap !== 1'b1) begin bad++; $display("FAIL trap_head got order=%0d trap=%b want 0/1", out_order, out_trap); end
        total++; if (out_rd_addr !== 5'd0 || out_int_valid !== 1'b0 || out_rd_wdata !== 32'd0) begin bad++; $display("FAIL trap_rd got rd=%0d iv=%b wd=%0d want 0/0/0", out_rd_addr, out_int_valid, out_rd_wdata); end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_order !== 64'd0 || out_pc_rdata !== 32'h304 || out_int_valid !== 1'b1) begin bad++; $display("FAIL trap_follow got order=%0d pc=%h iv=%b want 0/304/1", out_order, out_pc_rdata, out_int_valid); end
        set_lane(0, 32'h308, 32'h13, 1'b0, 1'b0, 5'd6, 32'd66, 1'b1);
        @(negedge clk);
        clear_inputs();
        total++; if (out_order !== 64'd1 || out_pc_rdata !== 32'h308) begin bad++; $display("FAIL trap_next_group got order=%0d pc=%h want 1/308", out_order, out_pc_rdata); end
    endtask

    task automatic test_rd_zero();
        do_reset();
        set_lane(0, 32'h400, 32'h13, 1'b0, 1'b0, 5'd0, 32'hdead, 1'b1);
        @(negedge clk);
        clear_inputs();
        total++; if (out_valid !== 1'b1 || out_int_valid !== 1'b0) begin bad++; $display("FAIL rd0_valid got v=%b iv=%b want 1/0", out_valid, out_int_valid); end
        total++; if (out_rd_wdata !== 32'd0 || out_rd_addr !== 5'd0) begin bad++; $display("FAIL rd0_data got wd=%h rd=%0d want 0/0", out_rd_wdata, out_rd_addr); end
    endtask

    task automatic test_full_overflow();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_lane(0, 32'h1000 + 32'(8*k), 32'h13, 1'b0, 1'b0, 5'd1, 32'(2*k), 1'b1);
            set_lane(1, 32'h1004 + 32'(8*k), 32'h13, 1'b0, 1'b0, 5'd2, 32'(2*k+1), 1'b1);
            @(negedge clk);
            clear_inputs();
            if (k == 2) begin
                total++; if (ret_stall !== 1'b0 || count !== 4'd6) begin bad++; $display("FAIL full_six got stall=%b cnt=%0d want 0/6", ret_stall, count); end
            end
        end
        total++; if (count !== 4'd8 || ret_stall !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL full_eight got cnt=%0d stall=%b ovf=%b want 8/1/0", count, ret_stall, overflow); end
        set_lane(0, 32'h9000, 32'h13, 1'b0, 1'b0, 5'd1, 32'd0, 1'b1);
        set_lane(1, 32'h9004, 32'h13, 1'b0, 1'b0, 5'd1, 32'd0, 1'b1);
        @(negedge clk);
        clear_inputs();
        total++; if (count !== 4'd8 || overflow !== 1'b1) begin bad++; $display("FAIL full_drop got cnt=%0d ovf=%b want 8/1", count, overflow); end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            total++; if (out_order !== 64'(k) || out_pc_rdata !== 32'h1000 + 32'(4*k)) begin bad++; $display("FAIL full_drain%0d got order=%0d pc=%h want %0d/%h", k, out_order, out_pc_rdata, k, 32'h1000 + 32'(4*k)); end
            @(negedge clk);
        end
        set_lane(0, 32'h2000, 32'h13, 1'b0, 1'b0, 5'd1, 32'd0, 1'b1);
        @(negedge clk);
        clear_inputs();
        total++; if (out_order !== 64'd8 || overflow !== 1'b1) begin bad++; $display("FAIL full_next_order got order=%0d ovf=%b want 8/1", out_order, overflow); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_lane(0, 32'h3000 + 32'(8*k), 32'h13, 1'b0, 1'b0, 5'd1, 32'd0, 1'b1);
            if (k < 3) set_lane(1, 32'h3004 + 32'(8*k), 32'h13, 1'b0, 1'b0, 5'd1, 32'd0, 1'b1);
            @(negedge clk);
            clear_inputs();
        end
        total++; if (count !== 4'd7 || out_order !== 64'd0) begin bad++; $display("FAIL b2b_seven got cnt=%0d order=%0d want 7/0", count, out_order); end
        out_ready = 1'b1;
        set_lane(0, 32'h301c, 32'h13, 1'b0, 1'b0, 5'd1, 32'd0, 1'b1);
        @(negedge clk);
        clear_inputs();
        out_ready = 1'b0;
        total++; if (count !== 4'd7 || out_order !== 64'd1 || out_pc_rdata !== 32'h3004) begin bad++; $display("FAIL b2b_pushpop got cnt=%0d order=%0d pc=%h want 7/1/3004", count, out_order, out_pc_rdata); end
        set_lane(0, 32'h4000, 32'h13, 1'b0, 1'b0, 5'd1, 32'd0, 1'b1);
        set_lane(1, 32'h4004, 32'h13, 1'b0, 1'b0, 5'd1, 32'd0, 1'b1);
        @(negedge clk);
        clear_inputs();
        total++; if (count !== 4'd7 || overflow !== 1'b1) begin bad++; $display("FAIL b2b_reject got cnt=%0d ovf=%b want 7/1", count, overflow); end
        out_ready = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin bad++; $display("FAIL midreset got v=%b cnt=%0d ovf=%b want 0/0/0", out_valid, count, overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic [63:0] ctr;
        logic        ovf;
        int          n;
        bit          pop;
        do_reset();
        q = {};
        ctr = '0;
        ovf = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            total++; if (count !== 4'(q.size()) || out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_occ cyc%0d got cnt=%0d v=%b want %0d", cyc, count, out_valid, q.size()); end
            total++; if (ret_stall !== ((DEPTH - q.size()) < NRET) || overflow !== ovf) begin bad++; $display("FAIL rnd_flags cyc%0d got stall=%b ovf=%b want ovf=%b", cyc, ret_stall, overflow, ovf); end
            if (q.size() != 0) begin
                e = q[0];
                total++; if (out_order !== e.order || out_pc_rdata !== e.pc_r || out_pc_wdata !== e.pc_w || out_insn !== e.insn) begin bad++; $display("FAIL rnd_head cyc%0d got order=%0d pc=%h want %0d/%h", cyc, out_order, out_pc_rdata, e.order, e.pc_r); end
                total++; if (out_trap !== e.trap || out_intr !== e.intr || out_int_valid !== e.iv || out_rd_addr !== e.rd || out_rd_wdata !== e.wd) begin bad++; $display("FAIL rnd_rd cyc%0d got t=%b i=%b iv=%b rd=%0d wd=%h want %b/%b/%b/%0d/%h", cyc, out_trap, out_intr, out_int_valid, out_rd_addr, out_rd_wdata, e.trap, e.intr, e.iv, e.rd, e.wd); end
            end else begin
                total++; if (out_order !== 64'd0 || out_rd_wdata !== 32'd0 || out_insn !== 32'd0) begin bad++; $display("FAIL rnd_empty_zero cyc%0d got order=%0d wd=%h insn=%h", cyc, out_order, out_rd_wdata, out_insn); end
            end
            clear_inputs();
            out_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < NRET; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    set_lane(i, $urandom, $urandom, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom_range(0, 1) == 1);
                end
            end
            n = 0;
            for (int i = 0; i < NRET; i++) n += ret_valid[i];
            pop = (q.size() != 0) && out_ready;
            if (n <= DEPTH - q.size()) begin
                for (int i = 0; i < NRET; i++) begin
                    if (ret_valid[i]) begin
                        e.order = ctr;
                        e.pc_r  = ret_pc_rdata[i*32 +: 32];
                        e.pc_w  = ret_pc_wdata[i*32 +: 32];
                        e.insn  = ret_insn[i*32 +: 32];
                        e.trap  = ret_trap[i];
                        e.intr  = ret_intr[i];
                        e.iv    = !ret_trap[i] && ret_wr_valid[i] && (ret_rd_addr[i*5 +: 5] != 0);
                        e.rd    = e.iv ? ret_rd_addr[i*5 +: 5] : 5'd0;
                        e.wd    = e.iv ? ret_rd_wdata[i*32 +: 32] : 32'd0;
                        q.push_back(e);
                        if (!e.trap && !e.intr) ctr++;
                    end
                end
            end else begin
                ovf = 1'b1;
            end
            if (pop) void'(q.pop_front());
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_dual();
        test_trap();
        test_rd_zero();
        test_full_overflow();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
